// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM codec serial interface.
package tdm_pkg;

   typedef enum logic {
      FS_HALF  = 1'b0,
      FS_PULSE = 1'b1
   } fs_mode_t;

   localparam int MAX_CH = 16;

   function automatic int frame_bits(input int n_ch, input int slot_w);
      return n_ch * slot_w;
   endfunction

   // Index width that never collapses to zero bits for single-entry ranges.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tdm_bitclk_gen.sv
// Divides clk down to the serial bit clock and flags the launch (bick fall)
// and capture (bick mid-high) cycles for the framing logic.
module tdm_bitclk_gen
   import tdm_pkg::*;
#(
   parameter int BICK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic bick,
   output logic launch,
   output logic capture
);

   localparam int DIV_W = idx_w(BICK_DIV);
   localparam logic [DIV_W-1:0] LAST = DIV_W'(BICK_DIV - 1);
   localparam logic [DIV_W-1:0] HALF = DIV_W'(BICK_DIV / 2);

   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic             bick_reg;

   always_comb begin
      div_cnt_next = (div_cnt_reg == LAST) ? '0 : div_cnt_reg + DIV_W'(1);
   end

   // bick is registered from the next count so it stays aligned with div_cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_reg <= '0;
         bick_reg    <= 1'b0;
      end else begin
         div_cnt_reg <= div_cnt_next;
         bick_reg    <= (div_cnt_next >= HALF);
      end
   end

   assign bick    = bick_reg;
   assign launch  = (div_cnt_reg == LAST);
   assign capture = (div_cnt_reg == HALF);

endmodule

// File: rtl/tdm_serdes.sv
// Left-justified TDM serializer/deserializer: shifts a frame of DAC samples
// out on sdin and assembles a frame of ADC samples from sdout.
module tdm_serdes #(
   parameter int W        = 16,
   parameter int N_CH     = 4,
   parameter int SLOT_W   = 32,
   parameter int BICK_DIV = 4,
   parameter int FS_PULSE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              bick,
   output logic              lrck,
   output logic              sdin,
   input  logic              sdout,
   input  logic              mute,
   input  logic [N_CH*W-1:0] sample_in,
   input  logic              in_valid,
   output logic              in_taken,
   output logic [N_CH*W-1:0] sample_out,
   output logic              out_valid,
   output logic              underrun
);

   localparam int FRAME   = tdm_pkg::frame_bits(N_CH, SLOT_W);
   localparam int BIT_W   = tdm_pkg::idx_w(FRAME);
   localparam int SLOT_IW = tdm_pkg::idx_w(N_CH);
   localparam int POS_W   = tdm_pkg::idx_w(SLOT_W);
   localparam tdm_pkg::fs_mode_t FS_MODE =
      (FS_PULSE != 0) ? tdm_pkg::FS_PULSE : tdm_pkg::FS_HALF;
   localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(FRAME - 1);
   localparam logic [BIT_W-1:0] HALF_IDX = BIT_W'(FRAME / 2);

   logic launch, capture;

   tdm_bitclk_gen #(.BICK_DIV(BICK_DIV)) u_bitclk (
      .clk     (clk),
      .rst_n   (rst_n),
      .bick    (bick),
      .launch  (launch),
      .capture (capture)
   );

   logic [W-1:0]      in_word [N_CH];
   logic [W-1:0]      tx_reg  [N_CH];
   logic [W-1:0]      rx_reg  [N_CH];
   logic [W-1:0]      rx_next [N_CH];
   logic [N_CH*W-1:0] rx_flat;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign in_word[gi]          = sample_in[gi*W +: W];
         assign rx_flat[gi*W +: W]   = rx_next[gi];
      end
   endgenerate

   logic               started_reg, lrck_reg, sdin_reg;
   logic               in_taken_reg, out_valid_reg, underrun_reg;
   logic [N_CH*W-1:0]  sample_out_reg;
   logic [BIT_W-1:0]   bit_idx_reg, bit_idx_next;
   logic               frame_start, take_new, cap_en, last_cap;
   logic               sdin_next, lrck_next;
   logic [SLOT_IW-1:0] l_slot, c_slot;
   logic [POS_W-1:0]   l_pos, c_pos;
   logic [W-1:0]       tx_word, tx_shift;

   // The first launch after reset opens frame 0 without advancing bit_idx.
   always_comb begin
      frame_start  = launch && (!started_reg || bit_idx_reg == LAST_IDX);
      take_new     = frame_start && in_valid;
      bit_idx_next = bit_idx_reg;
      if (launch) begin
         bit_idx_next = frame_start ? '0 : bit_idx_reg + BIT_W'(1);
      end

      l_slot    = SLOT_IW'(bit_idx_next / SLOT_W);
      l_pos     = POS_W'(bit_idx_next % SLOT_W);
      tx_word   = take_new ? in_word[l_slot] : tx_reg[l_slot];
      tx_shift  = tx_word << l_pos;
      sdin_next = !mute && tx_shift[W-1];
      if (FS_MODE == tdm_pkg::FS_HALF) begin
         lrck_next = (bit_idx_next < HALF_IDX);
      end else begin
         lrck_next = (bit_idx_next == '0);
      end

      c_slot   = SLOT_IW'(bit_idx_reg / SLOT_W);
      c_pos    = POS_W'(bit_idx_reg % SLOT_W);
      cap_en   = capture && started_reg;
      last_cap = cap_en && (bit_idx_reg == LAST_IDX);
      rx_next  = rx_reg;
      if (cap_en && (32'(c_pos) < W)) begin
         rx_next[c_slot] = {rx_reg[c_slot][W-2:0], sdout};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started_reg    <= 1'b0;
         bit_idx_reg    <= '0;
         lrck_reg       <= 1'b0;
         sdin_reg       <= 1'b0;
         in_taken_reg   <= 1'b0;
         out_valid_reg  <= 1'b0;
         underrun_reg   <= 1'b0;
         sample_out_reg <= '0;
         for (int c = 0; c < N_CH; c++) begin
            tx_reg[c] <= '0;
            rx_reg[c] <= '0;
         end
      end else begin
         in_taken_reg  <= take_new;
         out_valid_reg <= last_cap;
         rx_reg        <= rx_next;
         if (last_cap) begin
            sample_out_reg <= rx_flat;
         end
         if (launch) begin
            started_reg <= 1'b1;
            bit_idx_reg <= bit_idx_next;
            sdin_reg    <= sdin_next;
            lrck_reg    <= lrck_next;
            if (frame_start) begin
               if (in_valid) begin
                  tx_reg <= in_word;
               end else begin
                  underrun_reg <= 1'b1;
               end
            end
         end
      end
   end

   assign lrck       = lrck_reg;
   assign sdin       = sdin_reg;
   assign in_taken   = in_taken_reg;
   assign out_valid  = out_valid_reg;
   assign underrun   = underrun_reg;
   assign sample_out = sample_out_reg;

endmodule

// File: tb/tb_tdm_serdes.sv
// Loopback bench for tdm_serdes: per-slot serial model on sdin, frame
// scoreboard on sample_out, plus a pulse-sync instance for lrck width.
module tb_tdm_serdes;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bick, lrck, sdin, mute, in_valid, in_taken, out_valid, underrun;
   logic [63:0] sample_in, sample_out;

   logic         bick2, lrck2, sdin2, in_taken2, out_valid2, underrun2;
   logic [127:0] sample_in2 = '0;
   logic [127:0] sample_out2;

   always #5 clk = ~clk;

   tdm_serdes dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bick       (bick),
      .lrck       (lrck),
      .sdin       (sdin),
      .sdout      (sdin),
      .mute       (mute),
      .sample_in  (sample_in),
      .in_valid   (in_valid),
      .in_taken   (in_taken),
      .sample_out (sample_out),
      .out_valid  (out_valid),
      .underrun   (underrun)
   );

   tdm_serdes #(.W(16), .N_CH(8), .SLOT_W(32), .BICK_DIV(2), .FS_PULSE(1)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bick       (bick2),
      .lrck       (lrck2),
      .sdin       (sdin2),
      .sdout      (sdin2),
      .mute       (1'b0),
      .sample_in  (sample_in2),
      .in_valid   (1'b1),
      .in_taken   (in_taken2),
      .sample_out (sample_out2),
      .out_valid  (out_valid2),
      .underrun   (underrun2)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Model state shared between the monitor and the stimulus sequence.
   int          cyc, bitn, frame_no, taken_cnt, exp_taken;
   logic        exp_underrun;
   logic [15:0] cur_tx    [4];
   logic [15:0] exp_frame [4];
   logic [31:0] exp_acc, got_acc;
   logic [63:0] rx_q [$];

   initial begin
      int          slot, pos;
      logic        exp_bit;
      logic [15:0] tmp;
      logic [63:0] exp_w;
      cyc = 0; bitn = -1; frame_no = -1; taken_cnt = 0; exp_taken = 0;
      exp_underrun = 1'b0; exp_acc = '0; got_acc = '0;
      for (int c = 0; c < 4; c++) begin
         cur_tx[c] = '0;
         exp_frame[c] = '0;
      end
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            cyc = 0; bitn = -1; frame_no = -1; taken_cnt = 0;
            rx_q.delete();
            exp_underrun = 1'b0;
         end else begin
            cyc++;
            if (out_valid) begin
               if (rx_q.size() == 0) begin
                  check("ov_spurious", 64'd1, 64'd0);
               end else begin
                  exp_w = rx_q.pop_front();
                  check("sample_out", sample_out, exp_w);
                  check("ov_phase", 64'(cyc % 512), 64'd3);
                  $display("rx frame done: sample_out=%h expected=%h", sample_out, exp_w);
               end
            end
            if (cyc % 4 == 2) check("bick_hi", {63'd0, bick}, 64'd1);
            if (cyc % 4 == 0) begin
               check("bick_lo", {63'd0, bick}, 64'd0);
               bitn = (bitn + 1) % 128;
               if (bitn == 0) begin
                  if (frame_no >= 0)
                     check($sformatf("in_taken_cnt f%0d", frame_no), 64'(taken_cnt), 64'(exp_taken));
                  frame_no++;
                  taken_cnt = 0;
                  exp_taken = in_valid ? 1 : 0;
                  if (in_valid) begin
                     for (int c = 0; c < 4; c++) cur_tx[c] = sample_in[c*16 +: 16];
                  end else begin
                     exp_underrun = 1'b1;
                  end
                  check("underrun", {63'd0, underrun}, {63'd0, exp_underrun});
               end
               check("lrck", {63'd0, lrck}, (bitn < 64) ? 64'd1 : 64'd0);
               slot = bitn / 32;
               pos  = bitn % 32;
               tmp  = cur_tx[slot];
               exp_bit = (!mute && pos < 16) ? tmp[15-pos] : 1'b0;
               exp_acc = {exp_acc[30:0], exp_bit};
               got_acc = {got_acc[30:0], sdin};
               if (pos == 31) begin
                  check($sformatf("sdin f%0d s%0d", frame_no, slot), {32'd0, got_acc}, {32'd0, exp_acc});
                  exp_frame[slot] = exp_acc[31:16];
               end
               if (bitn == 127)
                  rx_q.push_back({exp_frame[3], exp_frame[2], exp_frame[1], exp_frame[0]});
            end
            if (in_taken) taken_cnt++;
         end
      end
   end

   // Pulse-sync instance: count lrck high cycles over two full frames.
   initial begin
      int   c2, hi, rises;
      logic prev;
      bit   done;
      c2 = 0; hi = 0; rises = 0; prev = 1'b0; done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            c2 = 0;
         end else begin
            c2++;
            if (!done && c2 >= 600 && c2 < 1624) begin
               if (lrck2) hi++;
               if (lrck2 && !prev) rises++;
            end
            if (!done && c2 == 1624) begin
               check("fs_pulse_hi", 64'(hi), 64'd4);
               check("fs_pulse_rises", 64'(rises), 64'd2);
               done = 1'b1;
            end
         end
         prev = lrck2;
      end
   end

   task automatic wait_bit(input int f, input int b);
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (frame_no == f && bitn == b) return;
      end
      check($sformatf("wait_timeout f%0d b%0d", f, b), 64'd0, 64'd1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_bick"},       {63'd0, bick},      64'd0);
      check({tag, "_lrck"},       {63'd0, lrck},      64'd0);
      check({tag, "_sdin"},       {63'd0, sdin},      64'd0);
      check({tag, "_in_taken"},   {63'd0, in_taken},  64'd0);
      check({tag, "_out_valid"},  {63'd0, out_valid}, 64'd0);
      check({tag, "_underrun"},   {63'd0, underrun},  64'd0);
      check({tag, "_sample_out"}, sample_out,         64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      mute      = 1'b0;
      in_valid  = 1'b1;
      sample_in = 64'h8001_1234_FFFF_0000;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      wait_bit(0, 20);
      sample_in = 64'h5A5A_C3C3_0F0F_7FFE;
      wait_bit(1, 60);
      in_valid = 1'b0;
      wait_bit(2, 50);
      in_valid  = 1'b1;
      sample_in = 64'hDEAD_BEEF_0123_4567;
      wait_bit(3, 40);
      mute      = 1'b1;
      sample_in = 64'h8000_0001_AAAA_5555;
      wait_bit(4, 100);
      mute = 1'b0;

      wait_bit(5, 70);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("async_rst");
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_hold_out_valid", {63'd0, out_valid}, 64'd0);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      sample_in = 64'h1357_9BDF_2468_ACE0;

      wait_bit(2, 10);
      check("final_underrun", {63'd0, underrun}, 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
